hmi_cmd_decoder: RTL and testbench

//  Parametrised host-byte command decoder. Sits between the host byte interface and the TDC core.

---
 rtl/hmi_pkg.sv | 9 +
 rtl/hmi_sync_edge.sv | 19 +
 rtl/hmi_cmd_decoder.sv | 158 +++++++++++++++
 tb/tb_hmi_cmd_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmi_pkg.sv
// hmi_pkg: opcode constants and FSM state encoding shared by the host command decoder.
package hmi_pkg;
    localparam logic [1:0] OP_EXT  = 2'b00;
    localparam logic [1:0] OP_CMD  = 2'b01;
    localparam logic [1:0] OP_ADDR = 2'b10;
    localparam logic [1:0] OP_SEL  = 2'b11;
    localparam logic [5:0] CMD_CLR_ERR = 6'd0;
    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_ADDR_HI, ST_STROBE, ST_READ} state_t;
endpackage

// File: rtl/hmi_sync_edge.sv
// hmi_sync_edge: SYNC_STAGES-deep synchroniser for the async byte strobe with a
// one-cycle pulse on each rising edge of the synchronised level.
module hmi_sync_edge #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic res_n,
    input  logic i_async,
    output logic o_rise
);
    // r_sync[SYNC_STAGES] is the previous synchronised level for edge detection
    logic [SYNC_STAGES:0] r_sync;

    always_ff @(posedge clk or negedge res_n)
        if (!res_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-1:0], i_async};

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
endmodule

// File: rtl/hmi_cmd_decoder.sv
// hmi_cmd_decoder: host-byte command decoder with skid buffer, two-byte addresses,
// programmable strobe length and sticky error. Macro HMI_BROADCAST_EN makes an all-ones sel_reg select every board.
module hmi_cmd_decoder
    import hmi_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int ID_W        = 3,
    parameter int NUM_CMD     = 6,
    parameter int STROBE_LEN  = 1,
    parameter int SYNC_STAGES = 3
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [7:0]          din,
    input  logic                din_rdy,
    input  logic [ID_W-1:0]     in_value,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic [NUM_CMD-1:0]  cmd_pulse,
    output logic                fpga_sel,
    output logic [2*ID_W+1:0]   fpga_sel_status,
    output logic                busy,
    output logic                err
);
    localparam logic [3:0] LEN_M1   = 4'(STROBE_LEN - 1);
    localparam bit         TWO_BYTE = ADDR_W > 6;

    logic               w_byte_vld, w_pop, w_err_set, w_err_clr, w_ovf;
    logic               r_skid_full, r_read, w_read_nxt, r_err;
    logic [7:0]         r_skid, r_byte;
    logic [1:0]         w_op;
    logic [5:0]         w_pl, r_lo6, w_lo6_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [NUM_CMD-1:0] r_cmd, w_cmd_nxt;
    logic [ID_W-1:0]    r_sel, w_sel_nxt;
    state_t             r_state, w_state_nxt;

    hmi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .res_n   (res_n),
        .i_async (din_rdy),
        .o_rise  (w_byte_vld)
    );

    assign w_op  = r_byte[7:6];
    assign w_pl  = r_byte[5:0];
    assign w_ovf = w_byte_vld & r_skid_full & ~w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lo6_nxt   = r_lo6;
        w_addr_nxt  = r_addr;
        w_read_nxt  = r_read;
        w_cmd_nxt   = r_cmd;
        w_sel_nxt   = r_sel;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_skid_full) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_nxt = ST_IDLE;
                case (w_op)
                    OP_EXT: w_err_set = 1'b1;
                    OP_CMD:
                        if (w_pl == CMD_CLR_ERR) w_err_clr = 1'b1;
                        else if (int'(w_pl) <= NUM_CMD) begin
                            w_cmd_nxt   = NUM_CMD'(1) << (w_pl - 6'd1);
                            w_cnt_nxt   = LEN_M1;
                            w_state_nxt = ST_STROBE;
                        end else w_err_set = 1'b1;
                    OP_ADDR:
                        if (TWO_BYTE) begin
                            w_lo6_nxt   = w_pl;
                            w_state_nxt = ST_ADDR_HI;
                        end else begin
                            w_addr_nxt  = ADDR_W'(w_pl);
                            w_read_nxt  = 1'b1;
                            w_cnt_nxt   = LEN_M1;
                            w_state_nxt = ST_READ;
                        end
                    default: w_sel_nxt = ID_W'(w_pl);
                endcase
            end
            // A non-extension byte aborts the address and stays in the skid to be decoded from IDLE
            ST_ADDR_HI: if (r_skid_full) begin
                if (r_skid[7:6] == OP_EXT) begin
                    w_pop       = 1'b1;
                    w_addr_nxt  = ADDR_W'({r_skid[5:0], r_lo6});
                    w_read_nxt  = 1'b1;
                    w_cnt_nxt   = LEN_M1;
                    w_state_nxt = ST_READ;
                end else begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STROBE, ST_READ:
                if (r_cnt == 4'd0) begin
                    w_cmd_nxt   = '0;
                    w_read_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else w_cnt_nxt = r_cnt - 4'd1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n)
        if (!res_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt       <= '0;
            r_lo6       <= '0;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_cmd       <= '0;
            r_sel       <= '1;
            r_err       <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid      <= '0;
            r_byte      <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_lo6  <= w_lo6_nxt;
            r_addr <= w_addr_nxt;
            r_read <= w_read_nxt;
            r_cmd  <= w_cmd_nxt;
            r_sel  <= w_sel_nxt;
            r_err  <= w_err_set | w_ovf | (r_err & ~w_err_clr);
            if (w_pop) r_byte <= r_skid;
            // A byte arriving on the popping cycle refills the skid instead of overflowing
            if (w_byte_vld && (!r_skid_full || w_pop)) begin
                r_skid      <= din;
                r_skid_full <= 1'b1;
            end else if (w_pop) r_skid_full <= 1'b0;
        end
    end

`ifdef HMI_BROADCAST_EN
    assign fpga_sel = (r_sel == in_value) | (&r_sel);
`else
    assign fpga_sel = (r_sel == in_value);
`endif

    assign address         = r_addr;
    assign read            = r_read;
    assign cmd_pulse       = r_cmd;
    assign err             = r_err;
    assign busy            = (r_state != ST_IDLE) | r_skid_full;
    assign fpga_sel_status = {fpga_sel, r_sel, r_err, in_value};
endmodule

// File: tb/tb_hmi_cmd_decoder.sv
// tb_hmi_cmd_decoder: directed vector table, skid-overflow and reset sequences, then random
// bytes checked against a transaction-level model of the decoder rules.
module tb_hmi_cmd_decoder;
    localparam int AW = 10, IW = 3, NC = 6, SL = 8, SS = 3;
`ifdef HMI_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic            clk = 1'b0, res_n = 1'b0, din_rdy = 1'b0;
    logic [7:0]      din = 8'h00;
    logic [IW-1:0]   in_value = 3'd2;
    logic [AW-1:0]   address;
    logic            read, fpga_sel, busy, err;
    logic [NC-1:0]   cmd_pulse;
    logic [2*IW+1:0] fpga_sel_status;

    int n_chk = 0, n_fail = 0;
    int d_cmd[NC] = '{default: 0};
    int run_cmd[NC] = '{default: 0};
    int d_read = 0, run_read = 0;

    logic [AW-1:0] m_addr;
    logic          m_err, m_pend;
    logic [IW-1:0] m_sel;
    int            m_lo, m_read;
    int            m_cmd[NC];

    typedef struct {
        logic [7:0]    b;
        logic [AW-1:0] addr;
        logic          e;
        logic          bsy;
        logic [IW-1:0] sel;
        int            rd;
        int            cmd;
    } vec_t;
    vec_t tbl[13];

    hmi_cmd_decoder #(
        .ADDR_W(AW), .ID_W(IW), .NUM_CMD(NC), .STROBE_LEN(SL), .SYNC_STAGES(SS)
    ) dut (
        .clk             (clk),
        .res_n           (res_n),
        .din             (din),
        .din_rdy         (din_rdy),
        .in_value        (in_value),
        .address         (address),
        .read            (read),
        .cmd_pulse       (cmd_pulse),
        .fpga_sel        (fpga_sel),
        .fpga_sel_status (fpga_sel_status),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*IW+1:0] exp_status(input logic [IW-1:0] s, input logic e);
        return {(s == in_value) || (BCAST && (&s)), s, e, in_value};
    endfunction

    // Pulse accounting: total high cycles per strobe and length of every completed pulse
    always @(negedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < NC; i++) begin
                d_cmd[i] = 0;
                run_cmd[i] = 0;
            end
            d_read = 0;
            run_read = 0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (cmd_pulse[i]) begin
                    d_cmd[i]++;
                    run_cmd[i]++;
                end else if (run_cmd[i] != 0) begin
                    check($sformatf("cmd%0d_len", i), run_cmd[i], SL);
                    run_cmd[i] = 0;
                end
            end
            if (cmd_pulse != '0) check("cmd_onehot", $countones(cmd_pulse), 1);
            if (read) begin
                d_read++;
                run_read++;
            end else if (run_read != 0) begin
                check("read_len", run_read, SL);
                run_read = 0;
            end
        end
    end

    task automatic m_reset();
        m_addr = '0;
        m_err = 1'b0;
        m_pend = 1'b0;
        m_lo = 0;
        m_sel = '1;
        m_read = 0;
        for (int i = 0; i < NC; i++) m_cmd[i] = 0;
    endtask

    task automatic m_apply(input logic [7:0] b);
        int op = int'(b[7:6]);
        int p = int'(b[5:0]);
        if (m_pend) begin
            m_pend = 1'b0;
            if (op == 0) begin
                m_addr = AW'((p % (1 << (AW - 6))) * 64 + m_lo);
                m_read += SL;
                return;
            end
            m_err = 1'b1;
        end
        if (op == 0) m_err = 1'b1;
        else if (op == 1) begin
            if (p == 0) m_err = 1'b0;
            else if (p <= NC) m_cmd[p-1] += SL;
            else m_err = 1'b1;
        end else if (op == 2) begin
            m_pend = 1'b1;
            m_lo = p;
        end else m_sel = IW'(p % (1 << IW));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        din = b;
        din_rdy = 1'b1;
        repeat (6) @(negedge clk);
        din_rdy = 1'b0;
        repeat (SL + 14) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_addr"}, address, m_addr);
        check({tag, "_err"}, err, m_err);
        check({tag, "_busy"}, busy, m_pend);
        check({tag, "_status"}, fpga_sel_status, exp_status(m_sel, m_err));
        check({tag, "_reads"}, d_read, m_read);
        for (int i = 0; i < NC; i++) check($sformatf("%s_cmd%0d", tag, i), d_cmd[i], m_cmd[i]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd"}, cmd_pulse, 0);
        check({tag, "_read"}, read, 0);
        check({tag, "_addr"}, address, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_status"}, fpga_sel_status, {BCAST || (in_value == 3'd7), 3'd7, 1'b0, in_value});
    endtask

    initial begin
        int snap[NC];
        int snap_rd, wait_cnt;
        logic [7:0] rb;
        tbl[0]  = '{8'h8F, 10'h000, 1'b0, 1'b1, 3'd7, 0, 0};
        tbl[1]  = '{8'h0B, 10'h2CF, 1'b0, 1'b0, 3'd7, 1, 0};
        tbl[2]  = '{8'h8F, 10'h2CF, 1'b0, 1'b1, 3'd7, 0, 0};
        tbl[3]  = '{8'h43, 10'h2CF, 1'b1, 1'b0, 3'd7, 0, 3};
        tbl[4]  = '{8'h47, 10'h2CF, 1'b1, 1'b0, 3'd7, 0, 0};
        tbl[5]  = '{8'h40, 10'h2CF, 1'b0, 1'b0, 3'd7, 0, 0};
        tbl[6]  = '{8'h46, 10'h2CF, 1'b0, 1'b0, 3'd7, 0, 6};
        tbl[7]  = '{8'h05, 10'h2CF, 1'b1, 1'b0, 3'd7, 0, 0};
        tbl[8]  = '{8'h40, 10'h2CF, 1'b0, 1'b0, 3'd7, 0, 0};
        tbl[9]  = '{8'h80, 10'h2CF, 1'b0, 1'b1, 3'd7, 0, 0};
        tbl[10] = '{8'h3F, 10'h3C0, 1'b0, 1'b0, 3'd7, 1, 0};
        tbl[11] = '{8'hC7, 10'h3C0, 1'b0, 1'b0, 3'd7, 0, 0};
        tbl[12] = '{8'hC2, 10'h3C0, 1'b0, 1'b0, 3'd2, 0, 0};

        repeat (3) @(negedge clk);
        check_reset("rst0");
        res_n = 1'b1;
        m_reset();

        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < NC; i++) snap[i] = d_cmd[i];
            snap_rd = d_read;
            send(tbl[k].b);
            m_apply(tbl[k].b);
            check($sformatf("t%0d_addr", k), address, tbl[k].addr);
            check($sformatf("t%0d_err", k), err, tbl[k].e);
            check($sformatf("t%0d_busy", k), busy, tbl[k].bsy);
            check($sformatf("t%0d_fsel", k), fpga_sel, (tbl[k].sel == in_value) || (BCAST && tbl[k].sel == 3'd7));
            check($sformatf("t%0d_status", k), fpga_sel_status, exp_status(tbl[k].sel, tbl[k].e));
            check($sformatf("t%0d_reads", k), d_read - snap_rd, tbl[k].rd * SL);
            for (int i = 0; i < NC; i++)
                check($sformatf("t%0d_cmd%0d", k, i), d_cmd[i] - snap[i], (tbl[k].cmd == i + 1) ? SL : 0);
        end

        // Three strobes 4 cycles apart: second waits in the skid, third finds it full
        for (int i = 0; i < NC; i++) snap[i] = d_cmd[i];
        foreach (tbl[0].b[j]) begin end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            din = (k == 0) ? 8'h41 : (k == 1) ? 8'h46 : 8'h42;
            din_rdy = 1'b1;
            repeat (2) @(negedge clk);
            din_rdy = 1'b0;
            @(negedge clk);
        end
        repeat (3 * SL + 10) @(negedge clk);
        check("ovf_err", err, 1);
        check("ovf_cmd0", d_cmd[0] - snap[0], SL);
        check("ovf_cmd1", d_cmd[1] - snap[1], 0);
        check("ovf_cmd5", d_cmd[5] - snap[5], SL);
        m_apply(8'h41);
        m_apply(8'h46);
        m_err = 1'b1;
        check_model("ovf");

        for (int k = 0; k < 60; k++) begin
            rb[7:6] = 2'($urandom_range(0, 3));
            rb[5:0] = (rb[7:6] == 2'b01) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            in_value = IW'($urandom_range(0, 7));
            send(rb);
            m_apply(rb);
            check_model($sformatf("r%0d_%02h", k, rb));
        end

        // Reset in the middle of a strobe drops it immediately
        @(negedge clk);
        din = 8'h41;
        din_rdy = 1'b1;
        repeat (2) @(negedge clk);
        din_rdy = 1'b0;
        wait_cnt = 0;
        while (cmd_pulse == '0 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("mid_strobe_seen", cmd_pulse, 6'b000001);
        #2 res_n = 1'b0;
        #1 check_reset("rst1");
        @(negedge clk);
        res_n = 1'b1;
        m_reset();

        // A half-received address does not survive reset
        send(8'h8F);
        m_apply(8'h8F);
        check("pend_busy", busy, 1);
        #2 res_n = 1'b0;
        #1 check_reset("rst2");
        @(negedge clk);
        res_n = 1'b1;
        m_reset();
        send(8'h0B);
        m_apply(8'h0B);
        check_model("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
